// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory between the IF fetch port
// and the MEM-stage data port. Each access holds mem_en for MEM_LATENCY+1
// cycles and is completed by a one-cycle ready pulse to the requester.
// Optional build macro: MEM_ARB_STARVE_GUARD_EN (forces IF ahead after
// STARVE_LIMIT consecutive losses to DM; default build is strict DM priority).
module mips_mem_arbiter #(
    parameter int WORD_WIDTH    = 32,
    parameter int MEM_ADDR_SIZE = 32,
    parameter int MEM_LATENCY   = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     if_req,
    input  logic [MEM_ADDR_SIZE-1:0] if_addr,
    output logic [WORD_WIDTH-1:0]    if_rdata,
    output logic                     if_ready,
    input  logic                     dm_req,
    input  logic                     dm_we,
    input  logic [MEM_ADDR_SIZE-1:0] dm_addr,
    input  logic [WORD_WIDTH-1:0]    dm_wdata,
    output logic [WORD_WIDTH-1:0]    dm_rdata,
    output logic                     dm_ready,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0]    mem_wdata,
    input  logic [WORD_WIDTH-1:0]    mem_rdata,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    // Reject configurations the 4-bit wait counter or the starvation guard cannot honour.
    if (MEM_LATENCY < 0 || MEM_LATENCY > 15 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("mips_mem_arbiter: MEM_LATENCY must be 0..15 and STARVE_LIMIT >= 1");
    end

    state_t                   r_state;
    logic [3:0]               r_cnt;
    logic                     r_mask_if;
    logic                     r_mask_dm;
    logic                     r_if_ready;
    logic                     r_dm_ready;
    logic [WORD_WIDTH-1:0]    r_if_rdata;
    logic [WORD_WIDTH-1:0]    r_dm_rdata;
    logic                     r_mem_en;
    logic                     r_mem_we;
    logic [MEM_ADDR_SIZE-1:0] r_mem_addr;
    logic [WORD_WIDTH-1:0]    r_mem_wdata;

    logic w_final;
    logic w_arb;
    logic w_if_elig;
    logic w_dm_elig;
    logic w_force_if;
    logic w_grant_if;
    logic w_grant_dm;

    // The last access edge is also an arbitration point; the requester just
    // served sits out that decision, and in IDLE the registered mask carries
    // the same exclusion for exactly one more decision.
    assign w_final    = (r_state != IDLE) && (r_cnt == 4'd0);
    assign w_arb      = (r_state == IDLE) || w_final;
    assign w_if_elig  = if_req && !((r_state == IDLE) ? r_mask_if : (r_state == IF_ACC));
    assign w_dm_elig  = dm_req && !((r_state == IDLE) ? r_mask_dm : (r_state == DM_ACC));
    assign w_grant_if = w_arb && w_if_elig && (!w_dm_elig || w_force_if);
    assign w_grant_dm = w_arb && w_dm_elig && !w_force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] r_starve_cnt;

    assign w_force_if = w_if_elig && (r_starve_cnt >= STARVE_W'(STARVE_LIMIT));

    // Count IF losses to DM (saturating) and forget them once IF is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_grant_dm && w_if_elig && (r_starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    // Access sequencer: grant, count down wait states, capture read data and pulse ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_mask_if   <= 1'b0;
            r_mask_dm   <= 1'b0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            if (w_final) begin
                if (r_state == IF_ACC) begin
                    r_if_rdata <= mem_rdata;
                    r_if_ready <= 1'b1;
                end else begin
                    if (!r_mem_we) begin
                        r_dm_rdata <= mem_rdata;
                    end
                    r_dm_ready <= 1'b1;
                end
            end
            if ((r_state != IDLE) && !w_final) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (w_grant_dm) begin
                r_state     <= DM_ACC;
                r_cnt       <= LAT;
                r_mask_if   <= 1'b0;
                r_mask_dm   <= 1'b0;
                r_mem_en    <= 1'b1;
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end else if (w_grant_if) begin
                r_state    <= IF_ACC;
                r_cnt      <= LAT;
                r_mask_if  <= 1'b0;
                r_mask_dm  <= 1'b0;
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= if_addr;
            end else begin
                r_state   <= IDLE;
                r_cnt     <= 4'd0;
                r_mask_if <= w_final && (r_state == IF_ACC);
                r_mask_dm <= w_final && (r_state == DM_ACC);
                r_mem_en  <= 1'b0;
                r_mem_we  <= 1'b0;
            end
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ready  = r_dm_ready;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed testbench for mips_mem_arbiter: one instance with MEM_LATENCY=2
// and one with MEM_LATENCY=0, both fed by a stateless memory model.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we, busy;

    logic        z_if_req = 1'b0, z_dm_req = 1'b0, z_dm_we = 1'b0;
    logic [31:0] z_if_addr = '0, z_dm_addr = '0, z_dm_wdata = '0;
    logic [31:0] z_if_rdata, z_dm_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
    logic        z_if_ready, z_dm_ready, z_mem_en, z_mem_we, z_busy;

    int errors = 0;
    int checks = 0;

    // Memory contents: one fixed word at 0x40, an address-derived pattern elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    assign mem_rdata   = memWord(mem_addr);
    assign z_mem_rdata = memWord(z_mem_addr);

    always #5 clk = ~clk;

    mips_mem_arbiter #(.WORD_WIDTH(32), .MEM_ADDR_SIZE(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mips_mem_arbiter #(.WORD_WIDTH(32), .MEM_ADDR_SIZE(32), .MEM_LATENCY(0), .STARVE_LIMIT(4)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_rdata(z_if_rdata), .if_ready(z_if_ready),
        .dm_req(z_dm_req), .dm_we(z_dm_we), .dm_addr(z_dm_addr), .dm_wdata(z_dm_wdata),
        .dm_rdata(z_dm_rdata), .dm_ready(z_dm_ready),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(z_mem_rdata), .busy(z_busy)
    );

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if ({mem_en, mem_we, if_ready, dm_ready, busy} !== 5'b0) begin errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, if_ready, dm_ready, busy}); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++;
            $display("[TB] FAIL reset_membus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++;
            $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, dm_rdata); end
        checks++; if ({z_mem_en, z_busy, z_if_ready, z_dm_ready} !== 4'b0) begin errors++;
            $display("[TB] FAIL reset_lat0: got %b expected 0000", {z_mem_en, z_busy, z_if_ready, z_dm_ready}); end
    endtask

    task automatic test_if_read(input logic [31:0] addr);
        if_addr = addr;
        if_req  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            checks++; if (mem_en !== (k <= 3) || busy !== (k <= 3)) begin errors++;
                $display("[TB] FAIL if_en c%0d: got en=%b busy=%b expected %b", k, mem_en, busy, k <= 3); end
            checks++; if (if_ready !== (k == 4) || dm_ready !== 1'b0) begin errors++;
                $display("[TB] FAIL if_ready c%0d: got %b/%b expected %b/0", k, if_ready, dm_ready, k == 4); end
            if (k <= 3) begin
                checks++; if (mem_addr !== addr || mem_we !== 1'b0) begin errors++;
                    $display("[TB] FAIL if_addr c%0d: got %h we=%b expected %h we=0", k, mem_addr, mem_we, addr); end
            end
            if (k == 4) begin
                checks++; if (if_rdata !== memWord(addr)) begin errors++;
                    $display("[TB] FAIL if_rdata: got %h expected %h", if_rdata, memWord(addr)); end
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_dm_read();
        dm_addr = 32'h200; dm_we = 1'b0; dm_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            checks++; if (mem_en !== (k <= 3) || mem_we !== 1'b0) begin errors++;
                $display("[TB] FAIL dmr_en c%0d: got en=%b we=%b expected en=%b we=0", k, mem_en, mem_we, k <= 3); end
            checks++; if (dm_ready !== (k == 4) || if_ready !== 1'b0) begin errors++;
                $display("[TB] FAIL dmr_ready c%0d: got %b/%b expected %b/0", k, dm_ready, if_ready, k == 4); end
            if (k == 4) begin
                checks++; if (dm_rdata !== 32'hA5A50200) begin errors++;
                    $display("[TB] FAIL dmr_rdata: got %h expected a5a50200", dm_rdata); end
                dm_req = 1'b0;
            end
        end
    endtask

    task automatic test_dm_write();
        dm_addr = 32'h100; dm_wdata = 32'h12345678; dm_we = 1'b1; dm_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            checks++; if (mem_en !== (k <= 3) || mem_we !== (k <= 3)) begin errors++;
                $display("[TB] FAIL dmw_en c%0d: got en=%b we=%b expected %b", k, mem_en, mem_we, k <= 3); end
            checks++; if (dm_ready !== (k == 4)) begin errors++;
                $display("[TB] FAIL dmw_ready c%0d: got %b expected %b", k, dm_ready, k == 4); end
            checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) begin errors++;
                $display("[TB] FAIL dmw_bus c%0d: got %h/%h expected 00000100/12345678", k, mem_addr, mem_wdata); end
            if (k >= 4) begin
                checks++; if (dm_rdata !== 32'hA5A50200) begin errors++;
                    $display("[TB] FAIL dmw_rdata_hold c%0d: got %h expected a5a50200", k, dm_rdata); end
            end
            if (k == 4) begin dm_req = 1'b0; dm_we = 1'b0; end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expAddr;
        if_addr = 32'h40; dm_addr = 32'h300; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            nextCycle();
            expAddr = (k <= 3) ? 32'h300 : 32'h40;
            checks++; if (mem_en !== (k <= 6) || busy !== (k <= 6)) begin errors++;
                $display("[TB] FAIL b2b_en c%0d: got en=%b busy=%b expected %b", k, mem_en, busy, k <= 6); end
            checks++; if (dm_ready !== (k == 4) || if_ready !== (k == 7)) begin errors++;
                $display("[TB] FAIL b2b_ready c%0d: got dm=%b if=%b expected dm=%b if=%b", k, dm_ready, if_ready, k == 4, k == 7); end
            if (k <= 6) begin
                checks++; if (mem_addr !== expAddr) begin errors++;
                    $display("[TB] FAIL b2b_addr c%0d: got %h expected %h", k, mem_addr, expAddr); end
            end
            if (k == 4) begin
                checks++; if (dm_rdata !== 32'hA5A50300) begin errors++;
                    $display("[TB] FAIL b2b_dm_rdata: got %h expected a5a50300", dm_rdata); end
                dm_req = 1'b0;
            end
            if (k == 7) begin
                checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++;
                    $display("[TB] FAIL b2b_if_rdata: got %h expected deadbeef", if_rdata); end
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_abort();
        if_addr = 32'h80; if_req = 1'b1;
        nextCycle();
        nextCycle();
        checks++; if (mem_en !== 1'b1) begin errors++;
            $display("[TB] FAIL abort_pre: got en=%b expected 1", mem_en); end
        reset_n = 1'b0;
        #1;
        checks++; if ({mem_en, mem_we, busy, if_ready, dm_ready} !== 5'b0 || mem_addr !== 32'h0 || if_rdata !== 32'h0) begin errors++;
            $display("[TB] FAIL abort_clear: got ctrl=%b addr=%h if_rdata=%h expected 0", {mem_en, mem_we, busy, if_ready, dm_ready}, mem_addr, if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            checks++; if (if_ready !== 1'b0 || mem_en !== 1'b0) begin errors++;
                $display("[TB] FAIL abort_no_ready c%0d: got ready=%b en=%b expected 0/0", k, if_ready, mem_en); end
        end
    endtask

    task automatic test_latency0_alternate();
        logic [31:0] expAddr;
        z_if_addr = 32'h44; z_dm_addr = 32'h88; z_dm_we = 1'b0;
        z_if_req = 1'b1; z_dm_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            nextCycle();
            expAddr = (k % 2 == 1) ? 32'h88 : 32'h44;
            checks++; if (z_mem_en !== (k <= 6) || z_busy !== (k <= 6)) begin errors++;
                $display("[TB] FAIL lat0_en c%0d: got en=%b busy=%b expected %b", k, z_mem_en, z_busy, k <= 6); end
            checks++; if (z_dm_ready !== (k % 2 == 0 && k <= 6) || z_if_ready !== (k % 2 == 1 && k >= 3)) begin errors++;
                $display("[TB] FAIL lat0_ready c%0d: got dm=%b if=%b", k, z_dm_ready, z_if_ready); end
            if (k <= 6) begin
                checks++; if (z_mem_addr !== expAddr) begin errors++;
                    $display("[TB] FAIL lat0_addr c%0d: got %h expected %h", k, z_mem_addr, expAddr); end
            end
            if (k == 2) begin
                checks++; if (z_dm_rdata !== 32'hA5A50088) begin errors++;
                    $display("[TB] FAIL lat0_dm_rdata: got %h expected a5a50088", z_dm_rdata); end
            end
            if (k == 7) begin
                checks++; if (z_if_rdata !== 32'hA5A50044) begin errors++;
                    $display("[TB] FAIL lat0_if_rdata: got %h expected a5a50044", z_if_rdata); end
            end
            if (k == 6) begin z_if_req = 1'b0; z_dm_req = 1'b0; end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        test_if_read(32'h40);
        repeat (2) @(negedge clk);
        test_dm_read();
        repeat (2) @(negedge clk);
        test_dm_write();
        repeat (2) @(negedge clk);
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_reset_abort();
        test_if_read(32'h80);
        repeat (2) @(negedge clk);
        test_latency0_alternate();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
